// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic unit arbiter:
// opcode values, FSM state encoding and default datapath widths.
package logic_unit_pkg;

  localparam int LU_WIDTH = 16;
  localparam int LU_OPW   = 2;

  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } lu_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the two requesters and the shared logic unit.
// The master side is the requester pair; the slave side is the arbiter.
interface logic_unit_arbiter_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int OPW   = LU_OPW
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
  );

endinterface

// File: rtl/logic16_unit.sv
// Purely combinational bitwise logic unit: AND / OR / XOR / NOR over WIDTH bits.
module logic16_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r
);

  // Opcode decode onto the bitwise result
  always_comb begin
    r = {WIDTH{1'b0}};
    case (op)
      LOP_AND: r = a & b;
      LOP_OR:  r = a | b;
      LOP_XOR: r = a ^ b;
      LOP_NOR: r = ~(a | b);
      default: r = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters.
// Accept -> EXEC (compute) -> RESP (hold until owner takes it) -> IDLE.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int OPW   = LU_OPW
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_arbiter_if.slave bus
);

  lu_state_e        state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic             grant_s;
  logic             req0_ready_s;
  logic             req1_ready_s;
  logic [WIDTH-1:0] lu_r_s;

  logic16_unit #(.WIDTH(WIDTH)) u_logic16_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .r  (lu_r_s)
  );

  // Round-robin grant: on a tie the requester that did not win last time goes
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req0_ready_s = (state_q == IDLE) && bus.req0_valid && !grant_s;
    req1_ready_s = (state_q == IDLE) && bus.req1_valid &&  grant_s;
  end

  // Next-state and register updates for the accept/execute/respond cycle
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (req0_ready_s || req1_ready_s) begin
          op_d         = grant_s ? bus.req1_op : bus.req0_op;
          a_d          = grant_s ? bus.req1_a  : bus.req0_a;
          b_d          = grant_s ? bus.req1_b  : bus.req0_b;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d = lu_r_s;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_valid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the response
        if (!owner_q && bus.rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (owner_q && bus.rsp1_ready) begin
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= {OPW{1'b0}};
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      rsp_data_q   <= {WIDTH{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
